kernel_pipe_drain: RTL and testbench

Stream-control and output-buffer block at the tail of a pipeline of leaf map nodes. It tracks data validity through the kernel pipeline and drives the global `stall` input of every leaf node. It collects the last node's registered `out1` into a small FIFO and presents it downstream over a valid/ready handshake. Downstream backpressure is converted into `stall`, so no in-flight kernel data is ever dropped.

---
 rtl/tytra_stream_pkg.sv | 17 +
 rtl/tytra_sync_fifo.sv | 50 +++++
 rtl/kernel_pipe_drain.sv | 71 +++++++
 tb/tb_kernel_pipe_drain.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tytra_stream_pkg.sv
// Shared stream package for kernel pipeline tail blocks.
// Holds the parameter defaults, the pointer-width helper and the
// default-width data word type.
package tytra_stream_pkg;

  localparam int DATAW_DEF      = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic [DATAW_DEF-1:0] data_t;

  // Pointer width for an n-entry buffer.
  // Clamped to 1 so that a 1- or 2-entry buffer still gets a real pointer bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tytra_sync_fifo.sv
// Synchronous circular-buffer FIFO with entry count.
// Ports:
//   clk, rst         clock, synchronous active-high reset (pointers/count only)
//   push, wr_data    write wr_data at the tail
//   pop              drop the head entry
//   rd_data          head entry, read straight from storage (no output register)
//   occupancy        current number of stored entries (0..DEPTH)
// The caller guarantees no push when full without a pop, and no pop when empty.
module tytra_sync_fifo
  import tytra_stream_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = clog2_min1(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DATAW-1:0] wr_data,
  input  logic             pop,
  output logic [DATAW-1:0] rd_data,
  output logic [CW-1:0]    occupancy
);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is not reset; content is meaningless until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + CW'(push) - CW'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/kernel_pipe_drain.sv
// Tail block of a leaf-node kernel pipeline.
// Tracks which pipeline stages carry live data, buffers the final stage
// output in a FIFO and presents it downstream with valid/ready. Downstream
// backpressure freezes the whole pipeline through stall, so nothing in
// flight is dropped.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  upstream handshake on the kernel operand inputs
//   stall               freeze to every leaf node
//   pipe_data           registered out1 of the final leaf stage
//   out_valid, out_data, out_ready   downstream handshake
//   occupancy           FIFO entry count
module kernel_pipe_drain
  import tytra_stream_pkg::*;
#(
  parameter int DATAW      = DATAW_DEF,
  parameter int PIPE_LAT   = 1,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             stall,
  input  logic [DATAW-1:0] pipe_data,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    occupancy
);

  logic [PIPE_LAT-1:0] vld;
  logic                pop;
  logic                push;
  logic                full;

  // Valid tracker mirrors the leaf registers: advances only when they do.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (!stall) begin
      vld[0] <= in_valid;
      for (int i = 1; i < PIPE_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  assign pop       = out_valid & out_ready;
  assign full      = (occupancy == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO only stalls when
  // downstream is not taking the head word. This is the only path from
  // out_ready to an output.
  assign stall     = full & ~pop;
  assign in_ready  = ~stall;
  assign push      = vld[PIPE_LAT-1] & ~stall;
  assign out_valid = (occupancy != '0);

  tytra_sync_fifo #(
    .DATAW (DATAW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_data   (pipe_data),
    .pop       (pop),
    .rd_data   (out_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_kernel_pipe_drain.sv
// Bench for kernel_pipe_drain: one instance with a 1-stage adder leaf
// (PIPE_LAT=1) and one with an adder followed by two delay stages
// (PIPE_LAT=3). Expected words are queued on acceptance and compared on pop.
module tb_kernel_pipe_drain;
  localparam int DW = 32;

  logic clk;
  logic rst;
  always #5 clk = ~clk;

  // instance A, PIPE_LAT=1
  logic          iv_a, ordy_a, ir_a, st_a, ov_a;
  logic [DW-1:0] a_a, b_a, pd_a, od_a;
  logic [2:0]    occ_a;
  // instance B, PIPE_LAT=3
  logic          iv_b, ordy_b, ir_b, st_b, ov_b;
  logic [DW-1:0] a_b, b_b, pd_b, od_b;
  logic [2:0]    occ_b;

  kernel_pipe_drain #(.DATAW(DW), .PIPE_LAT(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .stall(st_a),
    .pipe_data(pd_a), .out_valid(ov_a), .out_data(od_a), .out_ready(ordy_a),
    .occupancy(occ_a));

  kernel_pipe_drain #(.DATAW(DW), .PIPE_LAT(3), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .stall(st_b),
    .pipe_data(pd_b), .out_valid(ov_b), .out_data(od_b), .out_ready(ordy_b),
    .occupancy(occ_b));

  // leaf pipelines: adder register, then plain delay registers, all frozen by stall
  logic [DW-1:0] leaf_a;
  logic [DW-1:0] leaf_b [3];
  always_ff @(posedge clk) begin
    if (rst) leaf_a <= '0;
    else if (!st_a) leaf_a <= a_a + b_a;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) leaf_b[i] <= '0;
    end else if (!st_b) begin
      leaf_b[0] <= a_b + b_b;
      leaf_b[1] <= leaf_b[0];
      leaf_b[2] <= leaf_b[1];
    end
  end
  assign pd_a = leaf_a;
  assign pd_b = leaf_b[2];

  int tests = 0;
  int fails = 0;
  int npop_a = 0;
  int npop_b = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          s_ov, s_stall, s_ir, s_acc;
  logic [DW-1:0] s_od;
  logic [2:0]    s_occ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance d: drive, sample before the edge,
  // update the scoreboard, then advance past the edge.
  task automatic cyc(input int d, input logic iv, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input logic ordy);
    int qs;
    logic [DW-1:0] exp;
    if (d == 0) begin iv_a = iv; a_a = a; b_a = b; ordy_a = ordy; end
    else        begin iv_b = iv; a_b = a; b_b = b; ordy_b = ordy; end
    #1;
    if (d == 0) begin s_ov = ov_a; s_od = od_a; s_occ = occ_a; s_stall = st_a; s_ir = ir_a; end
    else        begin s_ov = ov_b; s_od = od_b; s_occ = occ_b; s_stall = st_b; s_ir = ir_b; end
    s_acc = iv & s_ir;
    if (!rst) begin
      if (s_ov && ordy) begin
        if (d == 0) npop_a++; else npop_b++;
        qs = (d == 0) ? qa.size() : qb.size();
        chk("sb_has_entry", 64'(qs != 0), 64'(1));
        if (qs != 0) begin
          exp = (d == 0) ? qa.pop_front() : qb.pop_front();
          chk("sb_data", 64'(s_od), 64'(exp));
        end
      end
      if (s_acc) begin
        if (d == 0) qa.push_back(a + b); else qb.push_back(a + b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int np0;
    int sent;
    int guard;
    logic seen_full;
    logic bub;
    logic [DW-1:0] ra, rb;

    clk = 1'b0; rst = 1'b1;
    iv_a = 1'b0; ordy_a = 1'b0; a_a = '0; b_a = '0;
    iv_b = 1'b0; ordy_b = 1'b0; a_b = '0; b_b = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // reset state and idle hold
    chk("rst_b_stall", 64'(st_b), 64'(0));
    chk("rst_b_in_ready", 64'(ir_b), 64'(1));
    chk("rst_b_out_valid", 64'(ov_b), 64'(0));
    chk("rst_b_occ", 64'(occ_b), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, '0, '0, 1'b0);
      chk("rst_stall", 64'(s_stall), 64'(0));
      chk("rst_in_ready", 64'(s_ir), 64'(1));
      chk("rst_out_valid", 64'(s_ov), 64'(0));
      chk("rst_occ", 64'(s_occ), 64'(0));
    end

    // single word 3+4, latency PIPE_LAT+1
    cyc(0, 1'b1, 32'd3, 32'd4, 1'b1);
    chk("single_accept", 64'(s_acc), 64'(1));
    cyc(0, 1'b0, '0, '0, 1'b1);
    chk("single_early_valid", 64'(s_ov), 64'(0));
    cyc(0, 1'b0, '0, '0, 1'b1);
    chk("single_valid", 64'(s_ov), 64'(1));
    chk("single_data", 64'(s_od), 64'(7));
    cyc(0, 1'b0, '0, '0, 1'b1);
    chk("single_occ_back0", 64'(s_occ), 64'(0));
    chk("single_valid_low", 64'(s_ov), 64'(0));

    // fill with out_ready=0
    np0 = npop_a;
    k = 1;
    seen_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'(k <= 8), k, '0, 1'b0);
      chk("fill_occ_le4", 64'(s_occ <= 3'd4), 64'(1));
      if (s_occ == 3'd4 && !seen_full) begin
        seen_full = 1'b1;
        chk("fill_stall_rise", 64'(s_stall), 64'(1));
      end
      if (seen_full) begin
        chk("fill_hold_occ", 64'(s_occ), 64'(4));
        chk("fill_in_ready_low", 64'(s_ir), 64'(0));
      end
      if (s_acc) k++;
    end
    chk("fill_reached_full", 64'(seen_full), 64'(1));
    chk("fill_accepted5", 64'(k), 64'(6));
    chk("fill_leaf_holds5", 64'(pd_a), 64'(5));
    chk("fill_vld_holds", 64'(dut_a.vld[0]), 64'(1));

    // release: continuous out_ready
    for (int r = 0; r < 8; r++) begin
      cyc(0, 1'(k <= 8), k, '0, 1'b1);
      if (r == 0) chk("rel_stall_fall", 64'(s_stall), 64'(0));
      chk("rel_no_gap", 64'(s_ov), 64'(1));
      if (r <= 4) chk("rel_occ_hold4", 64'(s_occ), 64'(4));
      if (s_acc) k++;
    end
    cyc(0, 1'b0, '0, '0, 1'b1);
    chk("rel_drained_valid", 64'(s_ov), 64'(0));
    chk("rel_sb_empty", 64'(qa.size()), 64'(0));
    chk("rel_pop_count", 64'(npop_a - np0), 64'(8));

    // reset mid-stream: occupancy 3 with a live word in the leaf stage
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, 101 + i, '0, 1'b0);
    chk("mid_occ3", 64'(occ_a), 64'(3));
    chk("mid_vld_live", 64'(dut_a.vld != 0), 64'(1));
    rst = 1'b1;
    cyc(0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    qa.delete();
    chk("mid_occ0", 64'(occ_a), 64'(0));
    chk("mid_valid0", 64'(ov_a), 64'(0));
    chk("mid_stall0", 64'(st_a), 64'(0));
    np0 = npop_a;
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 201 + i, '0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(0, 1'b0, '0, '0, 1'b1);
    chk("mid_sb_empty", 64'(qa.size()), 64'(0));
    chk("mid_pop_count", 64'(npop_a - np0), 64'(3));

    // bubbles with random backpressure at PIPE_LAT=3
    sent = 0; guard = 0; bub = 1'b0;
    ra = $urandom; rb = $urandom;
    while (sent < 500 && guard < 20000) begin
      cyc(1, !bub, ra, rb, 1'($urandom_range(0, 1)));
      chk("bub_occ_le4", 64'(s_occ <= 3'd4), 64'(1));
      if (bub) bub = 1'b0;
      else if (s_acc) begin
        sent++;
        bub = 1'b1;
        ra = $urandom; rb = $urandom;
      end
      guard++;
    end
    chk("bub_sent", 64'(sent), 64'(500));
    guard = 0;
    while (qb.size() != 0 && guard < 100) begin
      cyc(1, 1'b0, '0, '0, 1'b1);
      guard++;
    end
    chk("bub_sb_empty", 64'(qb.size()), 64'(0));
    chk("bub_pop_count", 64'(npop_b), 64'(500));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
